card_blitter: RTL and testbench
===============================

CARD_BLITTER -- requirements
Module: card_blitter

Interface
REQ-001 SHALL have parameter CARD_W, default 16, meaning sprite width in pixels.
REQ-002 SHALL have parameter CARD_H, default 32, meaning sprite height in pixels; CARD_W*CARD_H = 512 card memory entries.
REQ-003 SHALL have port clock  input  1  single system clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to copy the card sprite into the frame buffer.
REQ-006 SHALL have port cardX  input  8  destination column of the sprite's top-left pixel, 0..255.
REQ-007 SHALL have port cardY  input  8  destination row of the sprite's top-left pixel, 0..239.
REQ-008 SHALL have port transpEn  input  1  when 1, card pixels equal to 3'b000 are not written.
REQ-009 SHALL have port cardRE  output  1  read enable to the card memory.
REQ-010 SHALL have port cardAddr  output  9  read address to the card memory, row*CARD_W+col.
REQ-011 SHALL have port cardData  input  3  card memory read data, valid one cycle after cardAddr is presented.
REQ-012 SHALL have port fbWE  output  1  frame buffer write enable.
REQ-013 SHALL have port fbAddr  output  16  frame buffer write address, y*256+x.
REQ-014 SHALL have port fbData  output  3  frame buffer write pixel.
REQ-015 SHALL have port busy  output  1  high while a copy is in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse when a copy completes.

Function
REQ-017 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-018 SHALL in IDLE on start=1 latch cardX, cardY and transpEn, and enter RUN next cycle.
REQ-019 SHALL ignore start in any state other than IDLE, with no effect on the latched values.
REQ-020 SHALL in RUN drive cardRE=1 and a registered cardAddr of 0,1,...,511, one address per cycle in raster order.
REQ-021 SHALL enter FLUSH after the cycle cardAddr=511 and drive cardRE=0 in FLUSH.
REQ-022 SHALL register fbWE, fbAddr and fbData, so pixel k reaches the frame buffer two cycles after cardAddr=k is presented.
REQ-023 SHALL remain in FLUSH for 2 cycles so that pixel 511 is written, then enter DONE.
REQ-024 SHALL assert done for exactly the one DONE cycle, then return to IDLE.
REQ-025 SHALL assert busy in RUN, FLUSH and DONE, and deassert it in IDLE.
REQ-026 SHALL compute the destination with 9-bit sums: x = cardX + col and y = cardY + row.
REQ-027 SHALL suppress the write (fbWE=0) for any pixel with x > 255 or y > 239, giving clipping with no wrap-around.
REQ-028 SHALL suppress the write for any pixel whose cardData is 3'b000 while the latched transpEn is 1.
REQ-029 SHALL drive fbAddr = {y[7:0], x[7:0]} and fbData = cardData whenever fbWE=1.
REQ-030 SHALL hold fbWE=0 whenever no pixel write is due.
REQ-031 SHALL accept a start on the cycle immediately after done, with no dead cycle.
REQ-032 SHALL take, for a start accepted at cycle 0: first cardAddr at cycle 1, first fbWE at cycle 3, last fbWE at cycle 514, done at cycle 515.

Reset
REQ-033 SHALL on reset=1 enter IDLE and clear cardRE, cardAddr, fbWE, fbAddr, fbData, busy and done to 0 on the next edge.
REQ-034 SHALL on reset mid-copy perform no further frame buffer writes and ignore any in-flight card data.
REQ-035 SHALL give reset priority over start in the same cycle.

Verification
REQ-036 Bench SHALL cover: cardX=0, cardY=0, transpEn=0, card memory filled with addr[2:0] -> 512 writes, fbAddr=row*256+col, fbData=addr[2:0], done at cycle 515.
REQ-037 Bench SHALL cover: cardX=250, cardY=230 -> writes only for col 0..5 and row 0..9 (60 writes), no address wrap, done still at cycle 515.
REQ-038 Bench SHALL cover: transpEn=1 with even card addresses holding 3'b000 -> only the 256 odd-address pixels are written.
REQ-039 Bench SHALL cover: start pulsed again at cycles 10 and 300 of a copy -> ignored, exactly 512 writes, single done pulse.
REQ-040 Bench SHALL cover: reset asserted at cycle 100 of a copy -> fbWE=0 from cycle 101 onward, busy=0, no done pulse; a new start then completes normally.
REQ-041 Bench SHALL cover: start asserted in the cycle after done -> second copy begins with cardAddr=0 one cycle later.

Source files
------------

// File: rtl/card_blitter.sv
// ---------------------------------------------------------------------------
// card_blitter
//
// Copies a CARD_W x CARD_H sprite from a card memory into a 256x240 frame
// buffer at a chosen destination, with clipping on the right and bottom edges
// and optional transparency for pixel value 3'b000.
//
// Ports
//   clock     : system clock, all logic on the rising edge
//   reset     : synchronous active-high reset
//   start     : one-cycle copy request, honoured only while idle
//   cardX     : destination column of the sprite's top-left pixel
//   cardY     : destination row of the sprite's top-left pixel
//   transpEn  : when set, card pixels equal to 3'b000 are skipped
//   cardRE    : card memory read enable
//   cardAddr  : card memory read address (row*CARD_W + col)
//   cardData  : card memory read data, valid one cycle after cardAddr
//   fbWE      : frame buffer write enable
//   fbAddr    : frame buffer write address {y, x}
//   fbData    : frame buffer write pixel
//   busy      : high while a copy is in progress
//   done      : one-cycle pulse when a copy completes
// ---------------------------------------------------------------------------
module card_blitter #(
    parameter int CARD_W = 16,
    parameter int CARD_H = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  cardX,
    input  logic [7:0]  cardY,
    input  logic        transpEn,
    output logic        cardRE,
    output logic [8:0]  cardAddr,
    input  logic [2:0]  cardData,
    output logic        fbWE,
    output logic [15:0] fbAddr,
    output logic [2:0]  fbData,
    output logic        busy,
    output logic        done
);

    localparam logic [8:0] LAST_ADDR = 9'(CARD_W * CARD_H - 1);
    localparam logic [8:0] LAST_COL  = 9'(CARD_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t      state_q;

    // Copy parameters captured at start, so input changes mid-copy are harmless
    logic [7:0]  cardX_q;
    logic [7:0]  cardY_q;
    logic        transpEn_q;

    // Read stage: address plus the raster position it corresponds to
    logic        cardRE_q;
    logic [8:0]  addr_q;
    logic [8:0]  col_q;
    logic [8:0]  row_q;

    // Data stage: position of the pixel whose data is on cardData this cycle
    logic        rdValid_q;
    logic [8:0]  colRd_q;
    logic [8:0]  rowRd_q;

    logic        flushCnt_q;

    logic        fbWE_q;
    logic [15:0] fbAddr_q;
    logic [2:0]  fbData_q;
    logic        busy_q;
    logic        done_q;

    logic [8:0]  xSum;
    logic [8:0]  ySum;
    logic        fbWE_d;

    // Destination sums are 9 bits wide so an overflow past column 255 is
    // seen as off-screen instead of wrapping back to the left edge.
    always_comb begin
        xSum   = {1'b0, cardX_q} + colRd_q;
        ySum   = {1'b0, cardY_q} + rowRd_q;
        fbWE_d = rdValid_q
               & ~xSum[8]
               & (ySum <= 9'd239)
               & ~(transpEn_q & (cardData == 3'b000));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cardX_q    <= '0;
            cardY_q    <= '0;
            transpEn_q <= 1'b0;
            cardRE_q   <= 1'b0;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            rdValid_q  <= 1'b0;
            colRd_q    <= '0;
            rowRd_q    <= '0;
            flushCnt_q <= 1'b0;
            fbWE_q     <= 1'b0;
            fbAddr_q   <= '0;
            fbData_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Pipeline runs every cycle; rdValid_q gates whether it writes
            rdValid_q <= cardRE_q;
            colRd_q   <= col_q;
            rowRd_q   <= row_q;
            fbWE_q    <= fbWE_d;
            if (fbWE_d) begin
                fbAddr_q <= {ySum[7:0], xSum[7:0]};
                fbData_q <= cardData;
            end
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        cardX_q    <= cardX;
                        cardY_q    <= cardY;
                        transpEn_q <= transpEn;
                        cardRE_q   <= 1'b1;
                        addr_q     <= '0;
                        col_q      <= '0;
                        row_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (addr_q == LAST_ADDR) begin
                        cardRE_q   <= 1'b0;
                        flushCnt_q <= 1'b0;
                        state_q    <= FLUSH;
                    end else begin
                        addr_q <= addr_q + 9'd1;
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            row_q <= row_q + 9'd1;
                        end else begin
                            col_q <= col_q + 9'd1;
                        end
                    end
                end
                // Two cycles let the last read drain through the data and
                // write stages before completion is signalled.
                FLUSH: begin
                    flushCnt_q <= 1'b1;
                    if (flushCnt_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cardRE   = cardRE_q;
    assign cardAddr = addr_q;
    assign fbWE     = fbWE_q;
    assign fbAddr   = fbAddr_q;
    assign fbData   = fbData_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_card_blitter.sv
// ---------------------------------------------------------------------------
// tb_card_blitter
//
// Directed self-checking bench for card_blitter. A registered card memory
// model feeds the DUT; every cycle of each copy is compared against a small
// reference model of the expected raster timing, clipping and transparency.
// ---------------------------------------------------------------------------
module tb_card_blitter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  cardX = '0;
    logic [7:0]  cardY = '0;
    logic        transpEn = 1'b0;
    logic        cardRE;
    logic [8:0]  cardAddr;
    logic [2:0]  cardData = '0;
    logic        fbWE;
    logic [15:0] fbAddr;
    logic [2:0]  fbData;
    logic        busy;
    logic        done;

    logic [2:0]  mem [512];

    int checks = 0;
    int failures = 0;

    card_blitter #(
        .CARD_W(16),
        .CARD_H(32)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .cardX   (cardX),
        .cardY   (cardY),
        .transpEn(transpEn),
        .cardRE  (cardRE),
        .cardAddr(cardAddr),
        .cardData(cardData),
        .fbWE    (fbWE),
        .fbAddr  (fbAddr),
        .fbData  (fbData),
        .busy    (busy),
        .done    (done)
    );

    // 100 MHz-style clock, rising edges at 5, 15, 25 ...
    always #5 clock = ~clock;

    // Card memory with one cycle of read latency
    always @(posedge clock) begin
        if (cardRE) cardData <= mem[cardAddr];
    end

    // One comparison: counts it, and reports tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one copy whose start was driven in the current cycle (cycle 0).
    // Walks cycles 1..516 checking every output against the reference
    // model, scribbling over cardX/cardY/transpEn to prove they were
    // latched, re-pulsing start at again1/again2 and asserting reset at
    // resetAt (0 means never). Returns at the negedge of cycle 516.
    task automatic applyStimulus(input int cx, input int cy, input bit te,
                                 input int resetAt, input int again1,
                                 input int again2, input int expWrites);
        int  writes;
        int  k;
        int  x;
        int  y;
        bit  expWE;
        bit  afterReset;
        writes = 0;
        for (int c = 1; c <= 516; c++) begin
            @(negedge clock);
            start    = (c == again1) || (c == again2);
            reset    = (c == resetAt);
            cardX    = 8'(c * 37);
            cardY    = 8'(c * 11);
            transpEn = c[0];
            afterReset = (resetAt > 0) && (c > resetAt);
            if (fbWE === 1'b1) writes++;
            if (afterReset) begin
                checkOutput($sformatf("rst_fbWE c=%0d", c), 32'(fbWE), 32'd0);
                checkOutput($sformatf("rst_busy c=%0d", c), 32'(busy), 32'd0);
                checkOutput($sformatf("rst_done c=%0d", c), 32'(done), 32'd0);
                checkOutput($sformatf("rst_cardRE c=%0d", c), 32'(cardRE), 32'd0);
            end else begin
                checkOutput($sformatf("cardRE c=%0d", c), 32'(cardRE),
                            32'((c >= 1) && (c <= 512)));
                if (c <= 512)
                    checkOutput($sformatf("cardAddr c=%0d", c), 32'(cardAddr), 32'(c - 1));
                checkOutput($sformatf("busy c=%0d", c), 32'(busy), 32'(c <= 515));
                checkOutput($sformatf("done c=%0d", c), 32'(done), 32'(c == 515));
                k = c - 3;
                expWE = 1'b0;
                x = 0;
                y = 0;
                if (k >= 0 && k <= 511) begin
                    x = cx + (k % 16);
                    y = cy + (k / 16);
                    expWE = (x <= 255) && (y <= 239) && !(te && mem[k] == 3'b000);
                end
                checkOutput($sformatf("fbWE c=%0d", c), 32'(fbWE), 32'(expWE));
                if (expWE) begin
                    checkOutput($sformatf("fbAddr c=%0d", c), 32'(fbAddr), 32'(y * 256 + x));
                    checkOutput($sformatf("fbData c=%0d", c), 32'(fbData), 32'(mem[k]));
                end
            end
        end
        checkOutput("write_count", 32'(writes), 32'(expWrites));
    endtask

    // Begins a copy in the current cycle with the given destination
    task automatic kickCopy(input int cx, input int cy, input bit te);
        start    = 1'b1;
        cardX    = 8'(cx);
        cardY    = 8'(cy);
        transpEn = te;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 3'(i);

        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("reset_cardRE", 32'(cardRE), 32'd0);
        checkOutput("reset_cardAddr", 32'(cardAddr), 32'd0);
        checkOutput("reset_fbWE", 32'(fbWE), 32'd0);
        checkOutput("reset_fbAddr", 32'(fbAddr), 32'd0);
        checkOutput("reset_fbData", 32'(fbData), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Reset wins over a simultaneous start
        @(negedge clock);
        reset = 1'b1;
        kickCopy(0, 0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        checkOutput("rst_prio_busy", 32'(busy), 32'd0);
        checkOutput("rst_prio_cardRE", 32'(cardRE), 32'd0);
        @(negedge clock);
        checkOutput("rst_prio_busy2", 32'(busy), 32'd0);

        $display("[TB] full copy at origin");
        @(negedge clock);
        kickCopy(0, 0, 1'b0);
        applyStimulus(0, 0, 1'b0, 0, -1, -1, 512);

        $display("[TB] clipped copy at 250,230");
        @(negedge clock);
        kickCopy(250, 230, 1'b0);
        applyStimulus(250, 230, 1'b0, 0, -1, -1, 60);

        $display("[TB] transparent copy, even addresses zero");
        for (int i = 0; i < 512; i++) mem[i] = i[0] ? 3'(i) : 3'b000;
        @(negedge clock);
        kickCopy(5, 7, 1'b1);
        applyStimulus(5, 7, 1'b1, 0, -1, -1, 256);
        for (int i = 0; i < 512; i++) mem[i] = 3'(i);

        $display("[TB] start re-pulsed mid-copy");
        @(negedge clock);
        kickCopy(3, 4, 1'b0);
        applyStimulus(3, 4, 1'b0, 0, 10, 300, 512);

        $display("[TB] reset at cycle 100");
        @(negedge clock);
        kickCopy(0, 0, 1'b0);
        applyStimulus(0, 0, 1'b0, 100, -1, -1, 98);

        $display("[TB] copy after reset, then back-to-back copy");
        @(negedge clock);
        kickCopy(20, 40, 1'b0);
        applyStimulus(20, 40, 1'b0, 0, -1, -1, 512);
        kickCopy(100, 200, 1'b0);
        applyStimulus(100, 200, 1'b0, 0, -1, -1, 512);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
